core_writeback: RTL

- Writeback arbiter at the far end of the dual-issue pipeline. Issue sends work to the execution units; this block collects their results and drives the register file's two write ports.
- Sources:
  - ALU A and ALU B write immediately and are never stalled.
  - Multiplier, load/store and branch (link write) each get a one-entry holding buffer and a stall back-pressure output.
- Publishes a pending-write mask so issue hazard logic can block RAW on buffered results.

---
 rtl/core_writeback_pkg.sv | 30 +++
 rtl/core_wb_buffer.sv | 65 ++++++
 rtl/core_writeback.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/core_writeback_pkg.sv
// ----------------------------------------------------------------------------
// core_writeback_pkg
// Shared widths and types for the writeback stage.
//   word      : 32-bit architectural data value
//   reg_num   : 4-bit architectural register number
//   hword     : 16-bit mask, one bit per architectural register
//   wb_entry  : one pending register write {valid, rd, value}
//   onehot()  : register number to a single-bit register mask
// ----------------------------------------------------------------------------
package core_writeback_pkg;

    localparam int WORD_W    = 32;
    localparam int REG_NUM_W = 4;
    localparam int HWORD_W   = 16;

    typedef logic [WORD_W-1:0]    word;
    typedef logic [REG_NUM_W-1:0] reg_num;
    typedef logic [HWORD_W-1:0]   hword;

    typedef struct packed {
        logic   valid;
        reg_num rd;
        word    value;
    } wb_entry;

    function automatic hword onehot(input reg_num r);
        onehot = hword'(16'h0001) << r;
    endfunction

endpackage

// File: rtl/core_wb_buffer.sv
// ----------------------------------------------------------------------------
// core_wb_buffer
// One-entry holding buffer in front of the writeback arbiter for a single
// execution unit (multiplier, load/store or branch link).
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/rd/value : live result from the unit
//   drain             : the current candidate is consumed this cycle
//                       (granted a write port, or killed by a newer ALU write)
//   cand              : candidate presented to the arbiter; buffer contents
//                       when occupied, otherwise the live input (bypass)
//   stall             : buffer occupied and not draining; unit must hold
// ----------------------------------------------------------------------------
module core_wb_buffer
    import core_writeback_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    in_valid,
    input  reg_num  in_rd,
    input  word     in_value,
    input  logic    drain,
    output wb_entry cand,
    output logic    stall
);

    wb_entry buf_q;
    wb_entry buf_d;
    wb_entry live;

    always_comb begin
        live.valid = in_valid;
        live.rd    = in_rd;
        live.value = in_value;
    end

    // The buffered result is always older than the live input, so it has to
    // leave first; the live input only competes when the buffer is empty.
    always_comb begin
        cand  = buf_q.valid ? buf_q : live;
        stall = buf_q.valid && !drain;
    end

    // Occupied and draining: the unit saw stall low, so whatever it presents
    // now is a fresh result that takes the freed slot on the same edge.
    // Empty: a live result that was neither granted nor killed is captured.
    always_comb begin
        buf_d = buf_q;
        if (buf_q.valid) begin
            if (drain) begin
                buf_d = live;
            end
        end else if (in_valid && !drain) begin
            buf_d = live;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

endmodule

// File: rtl/core_writeback.sv
// ----------------------------------------------------------------------------
// core_writeback
// Writeback arbiter for the dual-issue pipeline. Collects results from two
// ALUs (never stalled) and three buffered units (ldst, mul, branch) and drives
// the two register-file write ports one cycle after the grant.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   alu_{a,b}_valid/rd/value   : ALU results, always granted
//   {mul,ldst,branch}_valid/rd/value : unit results
//   wb_stall_{mul,ldst,branch} : unit must hold its presented result
//   wr_en_{a,b}, wr_r_{a,b}, wr_value_{a,b} : registered write ports
//   mask_pending               : registers targeted by buffered results
//                                that are not leaving this cycle
// Candidate priority: alu_a, alu_b, ldst, mul, branch. First grant goes to
// port A, second to port B.
// ----------------------------------------------------------------------------
module core_writeback
    import core_writeback_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   alu_a_valid,
    input  reg_num alu_a_rd,
    input  word    alu_a_value,
    input  logic   alu_b_valid,
    input  reg_num alu_b_rd,
    input  word    alu_b_value,
    input  logic   mul_valid,
    input  reg_num mul_rd,
    input  word    mul_value,
    input  logic   ldst_valid,
    input  reg_num ldst_rd,
    input  word    ldst_value,
    input  logic   branch_valid,
    input  reg_num branch_rd,
    input  word    branch_value,
    output logic   wb_stall_mul,
    output logic   wb_stall_ldst,
    output logic   wb_stall_branch,
    output logic   wr_en_a,
    output logic   wr_en_b,
    output reg_num wr_r_a,
    output reg_num wr_r_b,
    output word    wr_value_a,
    output word    wr_value_b,
    output hword   mask_pending
);

    wb_entry cand_mul;
    wb_entry cand_ldst;
    wb_entry cand_branch;

    logic drain_mul;
    logic drain_ldst;
    logic drain_branch;

    logic grant_mul;
    logic grant_ldst;
    logic grant_branch;

    logic drop_mul;
    logic drop_ldst;
    logic drop_branch;

    hword alu_mask;
    logic free1;
    logic free2;
    logic elig_ldst;
    logic elig_mul;
    logic elig_branch;

    wb_entry req [5];
    wb_entry port_a_d;
    wb_entry port_b_d;

    core_wb_buffer u_buf_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (mul_valid),
        .in_rd    (mul_rd),
        .in_value (mul_value),
        .drain    (drain_mul),
        .cand     (cand_mul),
        .stall    (wb_stall_mul)
    );

    core_wb_buffer u_buf_ldst (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (ldst_valid),
        .in_rd    (ldst_rd),
        .in_value (ldst_value),
        .drain    (drain_ldst),
        .cand     (cand_ldst),
        .stall    (wb_stall_ldst)
    );

    core_wb_buffer u_buf_branch (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (branch_valid),
        .in_rd    (branch_rd),
        .in_value (branch_value),
        .drain    (drain_branch),
        .cand     (cand_branch),
        .stall    (wb_stall_branch)
    );

    // A unit candidate aimed at a register an ALU writes this cycle is stale
    // and is dropped. Among units sharing an rd only the highest-priority one
    // may go; the others wait so their writes stay in order. A dropped higher
    // unit shares its rd with an ALU, so the lower one is dropped as well.
    always_comb begin
        alu_mask = '0;
        if (alu_a_valid) alu_mask = alu_mask | onehot(alu_a_rd);
        if (alu_b_valid) alu_mask = alu_mask | onehot(alu_b_rd);

        drop_ldst   = cand_ldst.valid   && ((alu_mask & onehot(cand_ldst.rd))   != '0);
        drop_mul    = cand_mul.valid    && ((alu_mask & onehot(cand_mul.rd))    != '0);
        drop_branch = cand_branch.valid && ((alu_mask & onehot(cand_branch.rd)) != '0);

        elig_ldst   = cand_ldst.valid && !drop_ldst;
        elig_mul    = cand_mul.valid && !drop_mul
                      && !(cand_ldst.valid && cand_ldst.rd == cand_mul.rd);
        elig_branch = cand_branch.valid && !drop_branch
                      && !(cand_ldst.valid && cand_ldst.rd == cand_branch.rd)
                      && !(cand_mul.valid && cand_mul.rd == cand_branch.rd);

        free1 = !(alu_a_valid && alu_b_valid);
        free2 = !alu_a_valid && !alu_b_valid;

        grant_ldst = elig_ldst && free1;
        grant_mul  = elig_mul && (grant_ldst ? free2 : free1);
        if (grant_ldst && grant_mul) begin
            grant_branch = 1'b0;
        end else if (grant_ldst || grant_mul) begin
            grant_branch = elig_branch && free2;
        end else begin
            grant_branch = elig_branch && free1;
        end

        drain_ldst   = grant_ldst || drop_ldst;
        drain_mul    = grant_mul || drop_mul;
        drain_branch = grant_branch || drop_branch;
    end

    // Fill the two ports from the granted requests in priority order.
    always_comb begin
        req[0].valid = alu_a_valid;
        req[0].rd    = alu_a_rd;
        req[0].value = alu_a_value;
        req[1].valid = alu_b_valid;
        req[1].rd    = alu_b_rd;
        req[1].value = alu_b_value;
        req[2].valid = grant_ldst;
        req[2].rd    = cand_ldst.rd;
        req[2].value = cand_ldst.value;
        req[3].valid = grant_mul;
        req[3].rd    = cand_mul.rd;
        req[3].value = cand_mul.value;
        req[4].valid = grant_branch;
        req[4].rd    = cand_branch.rd;
        req[4].value = cand_branch.value;

        port_a_d = '0;
        port_b_d = '0;
        for (int i = 0; i < 5; i++) begin
            if (req[i].valid) begin
                if (!port_a_d.valid) begin
                    port_a_d = req[i];
                end else if (!port_b_d.valid) begin
                    port_b_d = req[i];
                end
            end
        end
    end

    // A buffer draining this cycle no longer blocks readers of its rd; that
    // is exactly the stall condition, so stall doubles as the mask qualifier.
    always_comb begin
        mask_pending = '0;
        if (wb_stall_ldst)   mask_pending = mask_pending | onehot(cand_ldst.rd);
        if (wb_stall_mul)    mask_pending = mask_pending | onehot(cand_mul.rd);
        if (wb_stall_branch) mask_pending = mask_pending | onehot(cand_branch.rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_a    <= 1'b0;
            wr_en_b    <= 1'b0;
            wr_r_a     <= '0;
            wr_r_b     <= '0;
            wr_value_a <= '0;
            wr_value_b <= '0;
        end else begin
            wr_en_a    <= port_a_d.valid;
            wr_en_b    <= port_b_d.valid;
            wr_r_a     <= port_a_d.rd;
            wr_r_b     <= port_b_d.rd;
            wr_value_a <= port_a_d.value;
            wr_value_b <= port_b_d.value;
        end
    end

endmodule
